commit_trace_buffer: RTL and testbench

Synthesizable on-chip replacement for per-cycle register dumping. Sits beside the single-cycle CPU core inside `sccomp_dataflow`. Records one entry per committed instruction into a circular buffer:

- PC
- instruction word
- register-file write (enable, address, data)
- cycle stamp

It supports wrap or fill-stop capture and an optional PC-match trigger with programmable post-trigger depth. After capture freezes, it drains entries oldest-first over a valid/ready stream.

---
 rtl/trace_pkg.sv | 29 ++
 rtl/trace_ram.sv | 27 ++
 rtl/commit_trace_buffer.sv | 193 +++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: FSM encoding, stored entry layout
// and capture-mode constants.
package trace_pkg;

    localparam int TR_PC_W    = 32;
    localparam int TR_DATA_W  = 32;
    localparam int TR_RADDR_W = 5;
    localparam int TR_CNT_W   = 32;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        POST   = 3'd2,
        FROZEN = 3'd3
    } state_t;

    typedef struct packed {
        logic [TR_PC_W-1:0]    pc;
        logic [TR_PC_W-1:0]    inst;
        logic                  we;
        logic [TR_RADDR_W-1:0] waddr;
        logic [TR_DATA_W-1:0]  wdata;
        logic [TR_CNT_W-1:0]   cycle;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Entry storage: register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module trace_ram
    import trace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = trace_entry_t
) (
    input  logic                       clk_in,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [$bits(entry_t)-1:0]  wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [$bits(entry_t)-1:0]  rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= entry_t'(wdata);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Circular trace of committed instructions with wrap/fill-stop capture, PC
// trigger with post-trigger depth, and an oldest-first valid/ready drain.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32,
    localparam int PW     = $clog2(DEPTH) + 1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               commit_valid,
    input  logic [PC_W-1:0]    commit_pc,
    input  logic [PC_W-1:0]    commit_inst,
    input  logic               rf_we,
    input  logic [RADDR_W-1:0] rf_waddr,
    input  logic [DATA_W-1:0]  rf_wdata,
    input  logic               arm,
    input  logic               cfg_mode,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic [PW-1:0]      post_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_inst,
    output logic               out_we,
    output logic [RADDR_W-1:0] out_waddr,
    output logic [DATA_W-1:0]  out_wdata,
    output logic [CNT_W-1:0]   out_cycle,
    output logic [2:0]         state_o,
    output logic [PW-1:0]      count_o,
    output logic               overflow_o
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    inst;
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
        logic [CNT_W-1:0]   cycle;
    } entry_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cyc_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]       count_q, post_rem_q;
    logic                overflow_q;

    logic   capturing, full, wr_en, trig_hit, post_done, fill_done, fill_stuck, xfer;
    entry_t wr_entry, rd_entry;
    logic [$bits(entry_t)-1:0] rd_bits;

    // A commit coinciding with arm is dropped so the fresh capture starts clean.
    assign capturing  = commit_valid && !arm && (state_q == ARMED || state_q == POST);
    assign full       = (count_q == PW'(DEPTH));
    assign fill_stuck = capturing && full && (cfg_mode == MODE_FILL);
    assign wr_en      = capturing && !fill_stuck;
    assign trig_hit   = wr_en && (state_q == ARMED) && trig_en && (commit_pc == trig_pc);
    assign post_done  = wr_en && (state_q == POST) && (post_rem_q == PW'(1));
    assign fill_done  = wr_en && (cfg_mode == MODE_FILL) && (count_q == PW'(DEPTH - 1));
    assign xfer       = out_valid && out_ready;

    assign wr_entry = '{
        pc:    commit_pc,
        inst:  commit_inst,
        we:    rf_we && (rf_waddr != '0),
        waddr: rf_waddr,
        wdata: rf_wdata,
        cycle: cyc_q
    };

    trace_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk_in (clk_in),
        .we     (wr_en),
        .waddr  (wr_ptr_q),
        .wdata  (wr_entry),
        .raddr  (rd_ptr_q),
        .rdata  (rd_bits)
    );

    assign rd_entry = entry_t'(rd_bits);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ARMED;
        end else begin
            unique case (state_q)
                IDLE:   state_d = IDLE;
                ARMED: begin
                    if ((trig_hit && post_count == '0) || fill_done || fill_stuck) begin
                        state_d = FROZEN;
                    end else if (trig_hit) begin
                        state_d = POST;
                    end
                end
                POST: begin
                    if (post_done || fill_done || fill_stuck) begin
                        state_d = FROZEN;
                    end
                end
                FROZEN: begin
                    if (count_q == '0 || (xfer && count_q == PW'(1))) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == FROZEN) && (count_q != '0);
        out_pc    = '0;
        out_inst  = '0;
        out_we    = 1'b0;
        out_waddr = '0;
        out_wdata = '0;
        out_cycle = '0;
        if (out_valid) begin
            out_pc    = rd_entry.pc;
            out_inst  = rd_entry.inst;
            out_we    = rd_entry.we;
            out_waddr = rd_entry.waddr;
            out_wdata = rd_entry.wdata;
            out_cycle = rd_entry.cycle;
        end
    end

    // Writes only happen in ARMED/POST and transfers only in FROZEN, so the
    // two pointer/count updates below never collide.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_rem_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (arm) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                post_rem_q <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (full) begin
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        overflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                if (trig_hit) begin
                    post_rem_q <= post_count;
                end else if (wr_en && state_q == POST) begin
                    post_rem_q <= post_rem_q - 1'b1;
                end
                if (xfer) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    count_q  <= count_q - 1'b1;
                end
            end
        end
    end

    assign state_o    = state_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a reference model queues the
// entries expected in the buffer and the drain pops and compares them.
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;
    localparam int PW    = 5;
    localparam logic [31:0] PCB = 32'h0040_0000;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0, commit_inst = '0;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0;
    logic        arm = 1'b0, cfg_mode = 1'b0, trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [PW-1:0] post_count = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_pc, out_inst, out_wdata, out_cycle;
    logic        out_we;
    logic [4:0]  out_waddr;
    logic [2:0]  state_o;
    logic [PW-1:0] count_o;
    logic        overflow_o;

    commit_trace_buffer dut (
        .clk_in(clk_in), .reset(reset), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_inst(commit_inst), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .arm(arm), .cfg_mode(cfg_mode),
        .trig_en(trig_en), .trig_pc(trig_pc), .post_count(post_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_we(out_we), .out_waddr(out_waddr),
        .out_wdata(out_wdata), .out_cycle(out_cycle), .state_o(state_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] cycle;
    } ent_t;

    ent_t mq[$];
    int   mstate;
    int   mrem;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] bcyc;

    // Reference cycle counter: counts every edge since reset release.
    always @(posedge clk_in or posedge reset) begin
        if (reset) bcyc <= '0;
        else       bcyc <= bcyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        mq.delete();
        mstate = 1;
        mrem = 0;
        step();
        arm = 1'b0;
    endtask

    function automatic logic [31:0] pc_of(input int k);
        return PCB + 32'(4 * k);
    endfunction

    task automatic model_commit(input logic [31:0] pc, input logic [31:0] inst,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ent_t e;
        if (mstate != 1 && mstate != 2) return;
        if (mq.size() == DEPTH) begin
            if (cfg_mode) return;
            void'(mq.pop_front());
        end
        e.pc = pc; e.inst = inst; e.we = we && (wa != 0);
        e.waddr = wa; e.wdata = wd; e.cycle = bcyc;
        mq.push_back(e);
        if (mstate == 1 && trig_en && pc == trig_pc) begin
            if (post_count == 0) mstate = 3;
            else begin mstate = 2; mrem = int'(post_count); end
        end else if (mstate == 2) begin
            mrem--;
            if (mrem == 0) mstate = 3;
        end
        if (cfg_mode && mq.size() == DEPTH) mstate = 3;
    endtask

    task automatic do_commit(input int k, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        commit_valid = 1'b1;
        commit_pc    = pc_of(k);
        commit_inst  = pc_of(k) ^ 32'hFFFF_0000;
        rf_we        = we;
        rf_waddr     = wa;
        rf_wdata     = wd;
        model_commit(commit_pc, commit_inst, we, wa, wd);
        step();
        commit_valid = 1'b0;
        rf_we        = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int   k = 0;
        ent_t e;
        while (mq.size() > 0 && k < 200) begin
            out_ready = toggle ? (k % 2 == 0) : 1'b1;
            e = mq[0];
            chk("drain_valid", out_valid, 1);
            chk("drain_pc", out_pc, e.pc);
            chk("drain_inst", out_inst, e.inst);
            chk("drain_we", out_we, e.we);
            chk("drain_waddr", out_waddr, e.waddr);
            chk("drain_wdata", out_wdata, e.wdata);
            chk("drain_cycle", out_cycle, e.cycle);
            if (!out_valid) break;
            step();
            if (out_ready) void'(mq.pop_front());
            else chk("stall_hold_pc", out_pc, e.pc);
            k++;
        end
        out_ready = 1'b0;
        chk("drain_left", mq.size(), 0);
        chk("drain_end_state", state_o, 0);
        chk("drain_end_valid", out_valid, 0);
        chk("drain_end_count", count_o, 0);
        mstate = 0;
    endtask

    initial begin
        mstate = 0;
        mrem = 0;
        reset = 1'b1;
        step();
        step();
        chk("rst_state", state_o, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_cycle", out_cycle, 0);
        @(negedge clk_in);
        reset = 1'b0;
        step();

        // Wrap overflow, frozen by a trigger on the last commit.
        cfg_mode = 1'b0; trig_en = 1'b1; trig_pc = pc_of(19); post_count = '0;
        arm_pulse();
        chk("arm_state", state_o, 1);
        for (int k = 0; k < 20; k++) do_commit(k, 1'b1, 5'(k + 1), 32'(k * 3));
        chk("wrap_state", state_o, 3);
        chk("wrap_count", count_o, 16);
        chk("wrap_ovf", overflow_o, 1);
        chk("wrap_first_pc", out_pc, pc_of(4));
        drain(1'b0);

        // Fill-stop: freezes on the 16th commit, later commits ignored.
        cfg_mode = 1'b1; trig_en = 1'b0;
        arm_pulse();
        for (int k = 0; k < 20; k++) begin
            do_commit(k, 1'b1, 5'(k), 32'h100 + 32'(k));
            if (k == 15) begin
                chk("fill_state", state_o, 3);
                chk("fill_count", count_o, 16);
            end
        end
        chk("fill_count_after", count_o, 16);
        chk("fill_ovf", overflow_o, 0);
        drain(1'b0);

        // Trigger at 0x00400010 with three post entries.
        cfg_mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h0040_0010; post_count = 5'd3;
        arm_pulse();
        for (int k = 0; k < 10; k++) begin
            do_commit(k, 1'b1, 5'd7, 32'(k));
            if (k == 4) chk("trig_post_state", state_o, 2);
            if (k == 7) begin
                chk("trig_frozen", state_o, 3);
                chk("trig_count", count_o, 8);
            end
        end
        chk("trig_last_count", count_o, 8);
        drain(1'b0);

        // Trigger with no post entries on the first commit.
        trig_pc = PCB; post_count = '0;
        arm_pulse();
        do_commit(0, 1'b0, 5'd3, 32'h55);
        chk("post0_valid", out_valid, 1);
        chk("post0_count", count_o, 1);
        drain(1'b0);

        // A write to $zero is recorded as no-write with data kept.
        arm_pulse();
        do_commit(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        chk("zero_we", out_we, 0);
        chk("zero_wdata", out_wdata, 32'hDEAD_BEEF);
        drain(1'b0);

        // Backpressure with ready toggling 1,0,1,0.
        cfg_mode = 1'b1; trig_en = 1'b0;
        arm_pulse();
        for (int k = 0; k < 16; k++) do_commit(k, 1'b1, 5'd9, 32'hA000 + 32'(k));
        drain(1'b1);

        // arm mid-drain aborts the drain.
        arm_pulse();
        for (int k = 0; k < 16; k++) do_commit(k, 1'b0, 5'd0, 32'(k));
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("abort_pre_count", count_o, 14);
        arm_pulse();
        chk("abort_valid", out_valid, 0);
        chk("abort_count", count_o, 0);
        chk("abort_state", state_o, 1);

        // Reset mid-POST takes effect without a clock edge.
        cfg_mode = 1'b0; trig_en = 1'b1; trig_pc = PCB; post_count = 5'd5;
        arm_pulse();
        do_commit(0, 1'b1, 5'd1, 32'h1);
        do_commit(1, 1'b1, 5'd1, 32'h2);
        chk("post_state", state_o, 2);
        chk("post_count", count_o, 2);
        #2 reset = 1'b1;
        #1;
        chk("areset_state", state_o, 0);
        chk("areset_count", count_o, 0);
        chk("areset_valid", out_valid, 0);
        chk("areset_ovf", overflow_o, 0);
        chk("areset_pc", out_pc, 0);
        @(negedge clk_in);
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
